key_bcd_counter: RTL

KEY_BCD_COUNTER -- requirements
Module: key_bcd_counter

---
 rtl/key_bcd_counter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/key_bcd_counter.sv
// Debounced two-key BCD up/down counter with four seven-segment displays.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits on hex3..hex1.

module key_bcd_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic max10_clk1_50,
    input  logic reset,
    input  logic key_n,
    output logic pressed,
    output logic press_evt
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          sync_pressed;

    assign sync_pressed = ~sync_q[1];

    always_ff @(posedge max10_clk1_50) begin
        if (reset) begin
            sync_q    <= 2'b11;
            cnt_q     <= '0;
            pressed   <= 1'b0;
            press_evt <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_n};
            press_evt <= 1'b0;
            if (sync_pressed == pressed) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                // This edge is the DEBOUNCE_CYCLES-th differing sample.
                cnt_q     <= '0;
                pressed   <= sync_pressed;
                press_evt <= sync_pressed;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

module key_bcd_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic        max10_clk1_50,
    input  logic        reset,
    input  logic [1:0]  key,
    input  logic [9:0]  sw,
    output logic [15:0] count,
    output logic [7:0]  hex0,
    output logic [7:0]  hex1,
    output logic [7:0]  hex2,
    output logic [7:0]  hex3,
    output logic [9:0]  ledr
);
    localparam int NUM_KEYS = 2;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] ZERO_HI = 8'hFF;
`else
    localparam logic [7:0] ZERO_HI = 8'hC0;
`endif

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    logic [NUM_KEYS-1:0] key_pressed, key_evt;
    logic [3:0][3:0]     count_q, inc_d, dec_d;
    logic                inc_wrap, dec_wrap;
    logic                wrap_q, dir_q;
    logic [3:1]          blank;
    logic                unused_sw;

    assign unused_sw = ^sw[7:0];

    generate
        for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
            key_bcd_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
                .max10_clk1_50 (max10_clk1_50),
                .reset         (reset),
                .key_n         (key[g]),
                .pressed       (key_pressed[g]),
                .press_evt     (key_evt[g])
            );
        end
    endgenerate

    // Ripple carry/borrow across digits; surviving carry means full wrap.
    always_comb begin
        inc_d    = count_q;
        dec_d    = count_q;
        inc_wrap = 1'b1;
        dec_wrap = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (inc_wrap) begin
                if (count_q[i] >= 4'd9) begin
                    inc_d[i] = 4'd0;
                end else begin
                    inc_d[i] = count_q[i] + 4'd1;
                    inc_wrap = 1'b0;
                end
            end
            if (dec_wrap) begin
                if (count_q[i] == 4'd0) begin
                    dec_d[i] = 4'd9;
                end else begin
                    dec_d[i] = count_q[i] - 4'd1;
                    dec_wrap = 1'b0;
                end
            end
        end
    end

    always_comb begin
        blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
        blank[3] = (count_q[3] == 4'd0);
        blank[2] = blank[3] && (count_q[2] == 4'd0);
        blank[1] = blank[2] && (count_q[1] == 4'd0);
`endif
    end

    always_ff @(posedge max10_clk1_50) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            dir_q   <= 1'b0;
            hex0    <= 8'hC0;
            hex1    <= ZERO_HI;
            hex2    <= ZERO_HI;
            hex3    <= ZERO_HI;
        end else begin
            dir_q <= sw[9];
            if (key_evt[1]) begin
                count_q <= '0;
                wrap_q  <= 1'b0;
            end else if (key_evt[0] && !sw[8]) begin
                if (sw[9]) begin
                    count_q <= dec_d;
                    if (dec_wrap) wrap_q <= 1'b1;
                end else begin
                    count_q <= inc_d;
                    if (inc_wrap) wrap_q <= 1'b1;
                end
            end
            hex0 <= seg7(count_q[0]);
            hex1 <= blank[1] ? 8'hFF : seg7(count_q[1]);
            hex2 <= blank[2] ? 8'hFF : seg7(count_q[2]);
            hex3 <= blank[3] ? 8'hFF : seg7(count_q[3]);
        end
    end

    assign count = count_q;
    assign ledr  = {dir_q, wrap_q, 6'b0, key_pressed};
endmodule
